uart_report_fmt: RTL and testbench
==================================

# uart_report_fmt

Formats a 32-bit measurement word and a one-byte tag into a fixed 16-byte NMEA-style ASCII line: `$T,HHHHHHHH*CC\r\n`. It sits directly upstream of `uart_send` in the GPSDO telemetry path. It feeds that block one byte at a time over the `uart_en` / `uart_din` / `uart_tx_busy` handshake, and consumes report requests from the frequency-measurement logic.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 16: maximum cycles to wait in REQ for `uart_tx_busy` to rise before the frame is aborted. Minimum legal value is 4.

Ports:
- `sys_clk`  in  1  system clock; the block's only clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `rpt_valid`  in  1  report request.
- `rpt_ready`  out  1  block can accept a report.
- `rpt_tag`  in  8  ASCII tag character, sent verbatim.
- `rpt_data`  in  32  value, sent as 8 uppercase hex digits, MSB first.
- `uart_tx_busy`  in  1  busy flag from `uart_send`.
- `uart_en`  out  1  byte request to `uart_send`; `uart_send` triggers on its rising edge.
- `uart_din`  out  8  byte to send.
- `frame_done`  out  1  one-cycle pulse when the final `\n` has finished transmitting.
- `frame_err`  out  1  one-cycle pulse on handshake timeout.

## Operation
- Frame byte index 0..15: `'$'`(0x24), tag, `','`(0x2C), hex digits of bits 31:28 down to 3:0, `'*'`(0x2A), checksum high nibble, checksum low nibble, 0x0D, 0x0A.
- Hex mapping:
  - nibble 0–9 → 0x30+n
  - nibble 10–15 → 0x37+n (uppercase)
- Checksum is the 8-bit XOR of bytes at index 1..10 (tag, comma, 8 digits). It is accumulated as each byte is loaded and cleared on accept. The value is final before index 12 is loaded.
- FSM states: IDLE, LOAD, REQ, WAIT.
  - IDLE: `rpt_ready = ~uart_tx_busy`. When `rpt_valid & rpt_ready`, latch `rpt_tag` and `rpt_data`, set index=0, clear checksum, go to LOAD.
  - LOAD: register `uart_din` = byte[index], set `uart_en`=1, clear the timeout counter, go to REQ.
  - REQ: hold `uart_en`=1 and `uart_din` stable.
    - When `uart_tx_busy`=1: drop `uart_en`, go to WAIT.
    - If `ACK_TIMEOUT` cycles elapse without busy: drop `uart_en`, pulse `frame_err`, go to IDLE.
  - WAIT: when `uart_tx_busy`=0:
    - if index=15: pulse `frame_done`, go to IDLE;
    - otherwise: increment index, go to LOAD.
- Request inputs are ignored outside IDLE. Latched data is immune to input changes mid-frame.
- Index is 4 bits and never wraps within a frame. Index 15 is terminal.

## Timing
- Reset values: `rpt_ready`=0 during reset, `uart_en`=0, `uart_din`=0x00, `frame_done`=0, `frame_err`=0, state=IDLE, index=0, checksum=0.
- All outputs are registered except `rpt_ready`, which is a combinational decode of state and `uart_tx_busy`.
- Accept occurs at edge N. At edge N+1, `uart_en`=1 and `uart_din`=0x24.
- With `uart_send`, busy rises 2 cycles after `uart_en` rises. `uart_din` therefore stays stable through that capture edge.
- `uart_en` is low for at least one full UART byte time between requests, which guarantees a fresh rising edge for every byte.
- Inter-byte gap after busy falls: 2 cycles (WAIT→LOAD, LOAD→REQ).
- `frame_done` asserts one cycle after busy falls following byte 15. `rpt_ready` can assert in that same cycle.
- Reset mid-frame: the block returns to IDLE at the next edge, and the partial frame is abandoned. No new frame starts until `uart_tx_busy`=0.
- `rpt_valid` arriving while busy is high from a foreign source is held off by `rpt_ready`=0.

## Structure
- Shared package `uart_report_pkg` holds:
  - the state encoding (IDLE/LOAD/REQ/WAIT);
  - `FRAME_LEN`=16;
  - ASCII constants `CH_DOLLAR`, `CH_COMMA`, `CH_STAR`, `CH_CR`, `CH_LF`;
  - the nibble-to-ASCII function.
- One sub-module, `uart_report_bytesel`: a combinational byte multiplexer from index, latched tag/data and checksum to a byte. The FSM, counters and checksum accumulator stay in the top level.

## Test plan
- Tag 0x46, data 0x0012ABCD, `uart_send` model (busy 2 cycles after `uart_en`) → bytes `$F,0012ABCD*6D\r\n`, in order. One `frame_done`, zero `frame_err`.
- Tag 0x45, data 0xFFFFFFFF → `$E,FFFFFFFF*69\r\n`. Checks even-count digit cancellation in the checksum.
- Model never raises busy → `uart_en` high for exactly `ACK_TIMEOUT` cycles. `frame_err` pulses once, the block returns to IDLE, and no `frame_done`.
- `rpt_valid` held high with `rpt_data` changing every cycle during a frame → the transmitted digits match the value latched at accept. The next frame starts only after `frame_done`.
- `sys_rst` pulsed while at byte 7 → outputs reach reset values at the next edge. With busy still high, `rpt_ready`=0 until busy falls. The next frame is complete and correct.
- Busy held high externally at idle → `rpt_ready`=0 and `uart_en` stays 0. Release busy → the request is accepted on the following cycle.

Source files
------------

// File: rtl/uart_report_pkg.sv
// uart_report_pkg
// Shared definitions for the telemetry line formatter:
//   - state_e    : formatter FSM encoding (IDLE/LOAD/REQ/WAIT)
//   - FRAME_LEN  : bytes per line "$T,HHHHHHHH*CC\r\n"
//   - CH_*       : fixed ASCII characters of the line
//   - nib2ascii  : 4-bit value to uppercase hex ASCII digit
package uart_report_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam int         FRAME_LEN = 16;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  // Bytes folded into the checksum: tag, comma and the eight digits.
  localparam logic [3:0] CSUM_FIRST = 4'd1;
  localparam logic [3:0] CSUM_LAST  = 4'd10;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

endpackage

// File: rtl/uart_report_bytesel.sv
// uart_report_bytesel
// Combinational byte multiplexer: picks the line byte for a frame index.
// Ports:
//   idx    in  4   frame byte index 0..15
//   tag    in  8   latched tag character
//   data   in  32  latched measurement word
//   csum   in  8   running XOR checksum (final by the time idx reaches 12)
//   byte_o out 8   ASCII byte for idx
module uart_report_bytesel
  import uart_report_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic [7:0]  tag,
  input  logic [31:0] data,
  input  logic [7:0]  csum,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx)
      4'd0:  byte_o = CH_DOLLAR;
      4'd1:  byte_o = tag;
      4'd2:  byte_o = CH_COMMA;
      // Hex digits, most significant nibble first.
      4'd3:  byte_o = nib2ascii(data[31:28]);
      4'd4:  byte_o = nib2ascii(data[27:24]);
      4'd5:  byte_o = nib2ascii(data[23:20]);
      4'd6:  byte_o = nib2ascii(data[19:16]);
      4'd7:  byte_o = nib2ascii(data[15:12]);
      4'd8:  byte_o = nib2ascii(data[11:8]);
      4'd9:  byte_o = nib2ascii(data[7:4]);
      4'd10: byte_o = nib2ascii(data[3:0]);
      4'd11: byte_o = CH_STAR;
      4'd12: byte_o = nib2ascii(csum[7:4]);
      4'd13: byte_o = nib2ascii(csum[3:0]);
      4'd14: byte_o = CH_CR;
      4'd15: byte_o = CH_LF;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_report_fmt.sv
// uart_report_fmt
// Turns a (tag, 32-bit value) report into the 16-byte ASCII line
// "$T,HHHHHHHH*CC\r\n" and feeds it byte by byte to uart_send.
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   rpt_valid/rpt_ready   report handshake; rpt_tag/rpt_data captured on accept
//   uart_tx_busy          busy flag from uart_send
//   uart_en/uart_din      byte request (uart_send acts on the rising edge of
//                         uart_en) and the byte itself
//   frame_done            1-cycle pulse once the final LF has been sent
//   frame_err             1-cycle pulse when busy never answers a request
// Handshakes:
//   rpt : a report transfers on a clock edge where rpt_valid & rpt_ready;
//         rpt_ready is high only in IDLE with uart_send idle and out of reset.
//   uart: uart_en rises with uart_din already valid and both are held until
//         uart_tx_busy is seen high (byte taken) or ACK_TIMEOUT cycles pass;
//         the next byte is only offered after busy has fallen again.
module uart_report_fmt
  import uart_report_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16  // >= 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rpt_valid,
  output logic        rpt_ready,
  input  logic [7:0]  rpt_tag,
  input  logic [31:0] rpt_data,
  input  logic        uart_tx_busy,
  output logic        uart_en,
  output logic [7:0]  uart_din,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int unsigned       TW       = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0]     TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    tag_q, tag_d;
  logic [31:0]   data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          en_q, en_d;
  logic [7:0]    din_q, din_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    sel_byte;

  uart_report_bytesel u_bytesel (
    .idx    (idx_q),
    .tag    (tag_q),
    .data   (data_q),
    .csum   (csum_q),
    .byte_o (sel_byte)
  );

  // Only combinational output; everything else leaves through a flop.
  assign rpt_ready  = ~sys_rst & (state_q == ST_IDLE) & ~uart_tx_busy;

  assign uart_en    = en_q;
  assign uart_din   = din_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    tag_d   = tag_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    en_d    = en_q;
    din_d   = din_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rpt_valid && rpt_ready) begin
          tag_d   = rpt_tag;
          data_d  = rpt_data;
          idx_d   = 4'd0;
          csum_d  = 8'h00;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        din_d   = sel_byte;
        en_d    = 1'b1;
        tmo_d   = '0;
        // Fold in each payload byte as it is loaded; the last one (idx 10)
        // lands two loads before the checksum digits are selected.
        if (idx_q >= CSUM_FIRST && idx_q <= CSUM_LAST) begin
          csum_d = csum_q ^ sel_byte;
        end
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (uart_tx_busy) begin
          en_d    = 1'b0;
          state_d = ST_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          // uart_en has now been high for ACK_TIMEOUT cycles.
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_WAIT: begin
        if (!uart_tx_busy) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LOAD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      csum_q  <= 8'h00;
      tag_q   <= 8'h00;
      data_q  <= 32'h0;
      tmo_q   <= '0;
      en_q    <= 1'b0;
      din_q   <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      en_q    <= en_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_report_fmt.sv
// tb_uart_report_fmt
// Bench for uart_report_fmt: a uart_send responder (busy rises two cycles
// after uart_en rises, stays high for BYTE_T cycles), a byte scoreboard fed
// from a reference frame builder, and directed steps in one initial block.
module tb_uart_report_fmt;

  localparam int TMO    = 8;
  localparam int BYTE_T = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [7:0]  rpt_tag;
  logic [31:0] rpt_data;
  logic        uart_tx_busy;
  logic        uart_en;
  logic [7:0]  uart_din;
  logic        frame_done;
  logic        frame_err;

  always #5 sys_clk = ~sys_clk;

  logic busy_m   = 1'b0;
  logic ext_busy = 1'b0;
  logic model_on = 1'b1;
  assign uart_tx_busy = busy_m | ext_busy;

  uart_report_fmt #(.ACK_TIMEOUT(TMO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_tag      (rpt_tag),
    .rpt_data     (rpt_data),
    .uart_tx_busy (uart_tx_busy),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rx_cnt = 0;
  int en_run = 0;
  int last_en_run = 0;
  int rise_cnt = 0;
  int hold = 0;
  logic en_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n > 4'd9) return 8'h41 + {4'h0, n - 4'd10};
    return 8'h30 + {4'h0, n};
  endfunction

  task automatic push_frame(input logic [7:0] t, input logic [31:0] d);
    logic [7:0] f[16];
    logic [7:0] cs;
    f[0] = 8'h24;
    f[1] = t;
    f[2] = 8'h2C;
    for (int i = 0; i < 8; i++) f[3+i] = hexc(d[31-4*i -: 4]);
    cs = 8'h00;
    for (int i = 1; i <= 10; i++) cs = cs ^ f[i];
    f[11] = 8'h2A;
    f[12] = hexc(cs[7:4]);
    f[13] = hexc(cs[3:0]);
    f[14] = 8'h0D;
    f[15] = 8'h0A;
    for (int i = 0; i < 16; i++) exp_q.push_back(f[i]);
  endtask

  // ---------------- uart_send responder + monitor (negedge) ----------------
  always @(negedge sys_clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (uart_en === 1'b1) en_run++;
    else if (en_prev) begin
      last_en_run = en_run;
      en_run = 0;
    end

    if (model_on && uart_en === 1'b1 && !en_prev) begin
      rise_cnt = 2;
    end else if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        busy_m = 1'b1;
        hold = BYTE_T;
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_byte: observed 0x%0h expected none", uart_din);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          n_cmp++;
          assert (uart_din === e) else begin
            n_err++;
            $error("FAIL byte#%0d: observed 0x%0h expected 0x%0h", rx_cnt, uart_din, e);
          end
        end
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) busy_m = 1'b0;
    end
    en_prev = (uart_en === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [7:0] t, input logic [31:0] d, input bit push);
    int w;
    w = 0;
    rpt_tag = t;
    rpt_data = d;
    rpt_valid = 1'b1;
    forever begin
      @(negedge sys_clk); #2;
      if (rpt_ready === 1'b1 || w >= 2000) break;
      w++;
    end
    chk("accept_ready", 32'(rpt_ready), 32'd1);
    if (push) push_frame(t, d);
    @(posedge sys_clk); #2;
    rpt_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > base) break;
      @(posedge sys_clk); #2;
    end
    chk("frame_done_seen", 32'(done_cnt > base), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int base, eb, rb, accepts, cyc;

  initial begin
    sys_rst = 1'b1;
    rpt_valid = 1'b0;
    rpt_tag = 8'h00;
    rpt_data = 32'h0;
    repeat (3) @(posedge sys_clk);
    #2;
    chk("rst_ready", 32'(rpt_ready), 32'd0);
    chk("rst_en", 32'(uart_en), 32'd0);
    chk("rst_din", 32'(uart_din), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #2;
    chk("idle_ready", 32'(rpt_ready), 32'd1);

    // Frame 1: $F,0012ABCD*6D
    base = done_cnt; eb = err_cnt; rb = rx_cnt;
    send_req(8'h46, 32'h0012ABCD, 1'b1);
    @(posedge sys_clk); #2;
    chk("first_en", 32'(uart_en), 32'd1);
    chk("first_din", 32'(uart_din), 32'h24);
    wait_done(base);
    chk("f1_bytes", 32'(rx_cnt - rb), 32'd16);
    chk("f1_q_empty", 32'(exp_q.size()), 32'd0);
    chk("f1_done_cnt", 32'(done_cnt - base), 32'd1);
    chk("f1_err_cnt", 32'(err_cnt - eb), 32'd0);

    // Frame 2: $E,FFFFFFFF*69
    base = done_cnt; rb = rx_cnt;
    send_req(8'h45, 32'hFFFFFFFF, 1'b1);
    wait_done(base);
    chk("f2_bytes", 32'(rx_cnt - rb), 32'd16);
    chk("f2_q_empty", 32'(exp_q.size()), 32'd0);

    // Timeout: busy never answers
    model_on = 1'b0;
    base = done_cnt; eb = err_cnt; rb = rx_cnt;
    send_req(8'h54, 32'h00000001, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (err_cnt > eb) break;
      @(posedge sys_clk); #2;
    end
    repeat (3) @(posedge sys_clk);
    #2;
    chk("tmo_en_cycles", 32'(last_en_run), 32'(TMO));
    chk("tmo_err_pulses", 32'(err_cnt - eb), 32'd1);
    chk("tmo_no_done", 32'(done_cnt - base), 32'd0);
    chk("tmo_idle_ready", 32'(rpt_ready), 32'd1);
    chk("tmo_en_low", 32'(uart_en), 32'd0);
    model_on = 1'b1;

    // Inputs changing every cycle while valid stays high
    base = done_cnt;
    accepts = 0; cyc = 0;
    rpt_tag = 8'h44;
    rpt_data = $urandom_range(32'hFFFFFFFF, 0);
    rpt_valid = 1'b1;
    while (accepts < 2 && cyc < 2000) begin
      @(negedge sys_clk); #2;
      if (rpt_ready === 1'b1) begin
        if (accepts == 1) chk("accept_after_done", 32'(done_cnt - base), 32'd1);
        push_frame(rpt_tag, rpt_data);
        accepts++;
      end
      @(posedge sys_clk); #2;
      rpt_data = $urandom_range(32'hFFFFFFFF, 0);
      rpt_tag = 8'($urandom_range(8'h5A, 8'h41));
      if (accepts == 2) rpt_valid = 1'b0;
      cyc++;
    end
    rpt_valid = 1'b0;
    chk("moving_accepts", 32'(accepts), 32'd2);
    wait_done(base + 1);
    chk("moving_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset while byte 7 is on the wire
    base = done_cnt; rb = rx_cnt;
    send_req(8'h52, 32'h89ABCDEF, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      if (rx_cnt >= rb + 8) break;
      @(posedge sys_clk); #2;
    end
    sys_rst = 1'b1;
    @(posedge sys_clk); #2;
    chk("mid_rst_en", 32'(uart_en), 32'd0);
    chk("mid_rst_din", 32'(uart_din), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);
    chk("mid_rst_ready", 32'(rpt_ready), 32'd0);
    chk("mid_rst_left", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    sys_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk); #2;
      if (uart_tx_busy !== 1'b1) break;
      chk("busy_hold_ready", 32'(rpt_ready), 32'd0);
    end
    chk("post_rst_ready", 32'(rpt_ready), 32'd1);
    base = done_cnt; rb = rx_cnt;
    @(posedge sys_clk); #2;
    send_req(8'h43, 32'hDEADBEEF, 1'b1);
    wait_done(base);
    chk("post_rst_bytes", 32'(rx_cnt - rb), 32'd16);
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    // Foreign busy at idle holds off the request
    base = done_cnt;
    ext_busy = 1'b1;
    rpt_tag = 8'h42;
    rpt_data = 32'h0;
    rpt_valid = 1'b1;
    repeat (4) begin
      @(posedge sys_clk); #2;
      chk("ext_busy_ready", 32'(rpt_ready), 32'd0);
      chk("ext_busy_en", 32'(uart_en), 32'd0);
    end
    push_frame(8'h42, 32'h0);
    ext_busy = 1'b0;
    #1;
    chk("release_ready", 32'(rpt_ready), 32'd1);
    @(posedge sys_clk); #2;
    rpt_valid = 1'b0;
    chk("release_accepted", 32'(rpt_ready), 32'd0);
    @(posedge sys_clk); #2;
    chk("release_en", 32'(uart_en), 32'd1);
    chk("release_din", 32'(uart_din), 32'h24);
    wait_done(base);
    chk("release_q_empty", 32'(exp_q.size()), 32'd0);
    chk("total_err_pulses", 32'(err_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
